nn_core_param: RTL and testbench
================================

NN_CORE_PARAM -- requirements
Module: nn_core_param

Interface
REQ-001 Parameter N_IN, default 784: input units per image.
REQ-002 Parameter N_HID, default 32: hidden units.
REQ-003 Parameter N_OUT, default 10: output classes, minimum 2.
REQ-004 Parameter DW, default 8: signed weight and activation width.
REQ-005 Parameter ACC_W, default 26: signed accumulator width.
REQ-006 Parameter SHIFT, default 7: accumulator LSB position mapped to LUT address bit 0.
REQ-007 Parameter LUT_AW, default 11: activation LUT address width.
REQ-008 Signals, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin inference; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid.
- class_idx  out  $clog2(N_OUT)  winning class; held until the next done.
- in_addr  out  $clog2(N_IN)  input-pixel read address.
- in_q  in  1  pixel bit; returned 1 cycle after in_addr.
- wh_addr  out  $clog2(N_HID*N_IN)  hidden-weight ROM address, equal to hid*N_IN+in.
- wh_q  in  DW  hidden weight; 1-cycle latency.
- wo_addr  out  $clog2(N_OUT*N_HID)  output-weight ROM address, equal to out*N_HID+hid.
- wo_q  in  DW  output weight; 1-cycle latency.
- lut_addr  out  LUT_AW  activation LUT address.
- lut_q  in  DW  activation value; 1-cycle latency.

Function
REQ-009 States: IDLE, HID_MAC, HID_DRAIN, HID_ACT, HID_WR, OUT_MAC, OUT_DRAIN, OUT_ACT, OUT_WR, DONE.
REQ-010 IDLE -> HID_MAC on start=1; MAC and all counters are cleared.
REQ-011 HID_MAC issues one in_addr/wh_addr pair per cycle for N_IN cycles, then moves to HID_DRAIN.
REQ-012 HID_DRAIN lasts 2 cycles, covering memory latency plus the MAC register.
REQ-013 HID_ACT presents lut_addr for 1 cycle.
REQ-014 HID_WR writes lut_q into the internal hidden buffer at index hid.
- If hid != N_HID-1: clear MAC, increment hid, go to HID_MAC.
- Else: go to OUT_MAC.
REQ-015 OUT_MAC, OUT_DRAIN, OUT_ACT and OUT_WR mirror the hidden phase with N_HID MAC cycles per output.
- Operand 1 is the hidden buffer value (1-cycle read); operand 2 is wo_q.
REQ-016 Exit of OUT_WR:
- When out=N_OUT-1, go to DONE.
- DONE asserts done for 1 cycle, then returns to IDLE.
REQ-017 Latency: done is high exactly 1+N_HID*(N_IN+4)+N_OUT*(N_HID+4) cycles after the edge that samples start; this is 25577 at defaults.
REQ-018 Pixel operand: in_q=1 maps to +(2^(DW-1)-1); in_q=0 maps to 0.
REQ-019 MAC: signed DW x DW product, sign-extended, accumulated into ACC_W bits without wrap checking.
REQ-020 LUT address rectification:
- Positive overflow beyond acc[SHIFT+LUT_AW-1] clamps to 2^(LUT_AW-1)-1.
- Negative overflow clamps to -2^(LUT_AW-1).
- Otherwise use acc[SHIFT+LUT_AW-1:SHIFT].
- The result is then offset by +2^(LUT_AW-1) (wrapping to offset-binary).
REQ-021 Argmax:
- Running compare on each OUT_WR value, signed.
- Strict greater-than; ties keep the lowest index.
- The first output initialises the maximum.
REQ-022 class_idx updates only in DONE.
REQ-023 start while busy=1 is ignored; start held high in IDLE after done begins a new run.

Reset
REQ-024 On rst_n=0 at any time, including mid-run, the FSM goes to IDLE and busy/done/class_idx/all addresses go to 0.
REQ-025 No done is produced for an aborted run.
REQ-026 Hidden buffer contents are not reset.

Configuration
REQ-027 With NN_SCORE_OUT_EN defined:
- Add output max_score (DW, signed), updated alongside class_idx, reset value 0.
REQ-028 Without NN_SCORE_OUT_EN: the port and its register are absent; all other behaviour is identical.

Structure
REQ-029 Package nn_pkg holds the state enum typedef and the default parameter constants.
REQ-030 One sub-module nn_mac (clear, operands, accumulator register) is instantiated once and shared by both phases.

Verification
REQ-031 Defaults, all in_q=0, all lut_q=0x10 -> done at cycle 25577, class_idx=0 (tie rule).
REQ-032 Output weights chosen so that output 7 alone maps to a LUT value of 0x70 and the others to 0x10 -> class_idx=7.
REQ-033 Accumulator forced to +2^20 -> lut_addr=0x7FF; forced to -2^20 -> lut_addr=0x000; forced to 0 -> lut_addr=0x400.
REQ-034 start pulsed at cycle 100 of a run -> no restart; done count unchanged.
REQ-035 rst_n low at cycle 5000, then start -> no done from the aborted run; new done 25577 cycles after the new start.
REQ-036 N_IN=16, N_HID=4, N_OUT=3, with NN_SCORE_OUT_EN -> done at cycle 1+4*20+3*8=105; max_score matches the reference-model maximum.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the two-layer binary-input classifier core:
// sequencer state encoding and default network dimensions.
package nn_pkg;

    localparam int NN_N_IN   = 784;
    localparam int NN_N_HID  = 32;
    localparam int NN_N_OUT  = 10;
    localparam int NN_DW     = 8;
    localparam int NN_ACC_W  = 26;
    localparam int NN_SHIFT  = 7;
    localparam int NN_LUT_AW = 11;

    typedef enum logic [3:0] {
        IDLE,
        HID_MAC,
        HID_DRAIN,
        HID_ACT,
        HID_WR,
        OUT_MAC,
        OUT_DRAIN,
        OUT_ACT,
        OUT_WR,
        DONE
    } nn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_mac.sv
// Signed multiply-accumulate with synchronous clear; one instance is
// time-shared between the hidden and output layers.
module nn_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_reg;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    // Accumulation wraps silently; sizing ACC_W is the integrator's job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/nn_core_param.sv
// Sequential MLP inference core: binary pixels -> hidden layer -> argmax.
// Optional max_score output is enabled by defining NN_SCORE_OUT_EN.
module nn_core_param
    import nn_pkg::*;
#(
    parameter int N_IN   = NN_N_IN,
    parameter int N_HID  = NN_N_HID,
    parameter int N_OUT  = NN_N_OUT,
    parameter int DW     = NN_DW,
    parameter int ACC_W  = NN_ACC_W,
    parameter int SHIFT  = NN_SHIFT,
    parameter int LUT_AW = NN_LUT_AW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(N_OUT)-1:0]          class_idx,
    output logic [$clog2(N_IN)-1:0]           in_addr,
    input  logic                              in_q,
    output logic [$clog2(N_HID*N_IN)-1:0]     wh_addr,
    input  logic signed [DW-1:0]              wh_q,
    output logic [$clog2(N_OUT*N_HID)-1:0]    wo_addr,
    input  logic signed [DW-1:0]              wo_q,
    output logic [LUT_AW-1:0]                 lut_addr,
`ifdef NN_SCORE_OUT_EN
    output logic signed [DW-1:0]              max_score,
`endif
    input  logic signed [DW-1:0]              lut_q
);

    localparam int IN_AW  = $clog2(N_IN);
    localparam int HID_AW = $clog2(N_HID);
    localparam int OUT_AW = $clog2(N_OUT);
    localparam int WH_AW  = $clog2(N_HID*N_IN);
    localparam int WO_AW  = $clog2(N_OUT*N_HID);
    localparam int MW     = $clog2(max_int(N_IN, N_HID));

    nn_state_t state_reg, state_next;

    logic [MW-1:0]     mac_cnt_reg;
    logic [HID_AW-1:0] hid_cnt_reg;
    logic [OUT_AW-1:0] out_cnt_reg;
    logic              drain_reg;
    logic [WH_AW-1:0]  wh_addr_reg;
    logic [WO_AW-1:0]  wo_addr_reg;
    logic              mac_en_reg;
    logic              op_out_reg;
    logic              done_reg;
    logic [OUT_AW-1:0] best_idx_reg;
    logic [OUT_AW-1:0] class_idx_reg;
    logic signed [DW-1:0] best_val_reg;

    logic signed [DW-1:0] hid_buf [N_HID];
    logic signed [DW-1:0] hid_rd_reg;

    logic mac_last, hid_last, out_last, mac_clear;
    logic signed [DW-1:0]    pix_op, op_a, op_b;
    logic signed [ACC_W-1:0] acc, acc_sh;
    logic [ACC_W-LUT_AW:0]   acc_upper;
    logic                    pos_ovf, neg_ovf;
    logic [LUT_AW-1:0]       lut_clamped;

    assign mac_last = (state_reg == OUT_MAC) ? (mac_cnt_reg == MW'(N_HID-1))
                                             : (mac_cnt_reg == MW'(N_IN-1));
    assign hid_last = (hid_cnt_reg == HID_AW'(N_HID-1));
    assign out_last = (out_cnt_reg == OUT_AW'(N_OUT-1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = HID_MAC;
            HID_MAC:   if (mac_last) state_next = HID_DRAIN;
            HID_DRAIN: if (drain_reg) state_next = HID_ACT;
            HID_ACT:   state_next = HID_WR;
            HID_WR:    state_next = hid_last ? OUT_MAC : HID_MAC;
            OUT_MAC:   if (mac_last) state_next = OUT_DRAIN;
            OUT_DRAIN: if (drain_reg) state_next = OUT_ACT;
            OUT_ACT:   state_next = OUT_WR;
            OUT_WR:    state_next = out_last ? DONE : OUT_MAC;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mac_cnt_reg   <= '0;
            hid_cnt_reg   <= '0;
            out_cnt_reg   <= '0;
            drain_reg     <= 1'b0;
            wh_addr_reg   <= '0;
            wo_addr_reg   <= '0;
            mac_en_reg    <= 1'b0;
            op_out_reg    <= 1'b0;
            done_reg      <= 1'b0;
            best_idx_reg  <= '0;
            best_val_reg  <= '0;
            class_idx_reg <= '0;
        end else begin
            state_reg  <= state_next;
            done_reg   <= (state_reg == DONE);
            // Operands return one cycle after their address, so the MAC enable lags the MAC state.
            mac_en_reg <= (state_reg == HID_MAC) || (state_reg == OUT_MAC);
            op_out_reg <= (state_reg == OUT_MAC);
            drain_reg  <= ((state_reg == HID_DRAIN) || (state_reg == OUT_DRAIN)) ? ~drain_reg : 1'b0;
            case (state_reg)
                IDLE: begin
                    mac_cnt_reg <= '0;
                    hid_cnt_reg <= '0;
                    out_cnt_reg <= '0;
                    wh_addr_reg <= '0;
                    wo_addr_reg <= '0;
                end
                HID_MAC: begin
                    mac_cnt_reg <= mac_last ? '0 : mac_cnt_reg + 1'b1;
                    wh_addr_reg <= wh_addr_reg + 1'b1;
                end
                HID_WR: hid_cnt_reg <= hid_last ? '0 : hid_cnt_reg + 1'b1;
                OUT_MAC: begin
                    mac_cnt_reg <= mac_last ? '0 : mac_cnt_reg + 1'b1;
                    wo_addr_reg <= wo_addr_reg + 1'b1;
                end
                OUT_WR: begin
                    if (!out_last) out_cnt_reg <= out_cnt_reg + 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if ((out_cnt_reg == '0) || (lut_q > best_val_reg)) begin
                        best_val_reg <= lut_q;
                        best_idx_reg <= out_cnt_reg;
                    end
                end
                DONE: class_idx_reg <= best_idx_reg;
                default: ;
            endcase
        end
    end

    // Hidden activations live in an unreset RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (state_reg == HID_WR) hid_buf[hid_cnt_reg] <= lut_q;
        if (state_reg == OUT_MAC) hid_rd_reg <= hid_buf[HID_AW'(mac_cnt_reg)];
    end

    assign pix_op    = {1'b0, {(DW-1){in_q}}};
    assign op_a      = op_out_reg ? hid_rd_reg : pix_op;
    assign op_b      = op_out_reg ? wo_q : wh_q;
    assign mac_clear = (state_reg == IDLE) || (state_reg == HID_WR) || (state_reg == OUT_WR);

    nn_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_clear),
        .en    (mac_en_reg),
        .a     (op_a),
        .b     (op_b),
        .acc   (acc)
    );

    // Saturate the scaled accumulator into a signed LUT index, then bias to offset-binary.
    assign acc_sh    = acc >>> SHIFT;
    assign acc_upper = acc_sh[ACC_W-1:LUT_AW-1];
    assign pos_ovf   = ~acc_sh[ACC_W-1] & (|acc_upper);
    assign neg_ovf   = acc_sh[ACC_W-1] & ~(&acc_upper);

    always_comb begin
        lut_clamped = acc_sh[LUT_AW-1:0];
        if (pos_ovf) lut_clamped = {1'b0, {(LUT_AW-1){1'b1}}};
        if (neg_ovf) lut_clamped = {1'b1, {(LUT_AW-1){1'b0}}};
        lut_addr = '0;
        if ((state_reg == HID_ACT) || (state_reg == OUT_ACT))
            lut_addr = {~lut_clamped[LUT_AW-1], lut_clamped[LUT_AW-2:0]};
        busy = (state_reg != IDLE);
    end

    assign done      = done_reg;
    assign class_idx = class_idx_reg;
    assign in_addr   = IN_AW'(mac_cnt_reg);
    assign wh_addr   = wh_addr_reg;
    assign wo_addr   = wo_addr_reg;

`ifdef NN_SCORE_OUT_EN
    logic signed [DW-1:0] max_score_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_score_reg <= '0;
        end else if (state_reg == DONE) begin
            max_score_reg <= best_val_reg;
        end
    end

    assign max_score = max_score_reg;
`else
    // Winning score stays internal in this build.
`endif

endmodule

// File: tb/tb_nn_core_param.sv
// Directed bench for nn_core_param: one default-size instance for latency and
// abort behaviour, one small instance for datapath, clamping and argmax.
module tb_nn_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- default-size instance ----------------
    logic        rst_n_d = 1'b0, start_d = 1'b0;
    logic        busy_d, done_d;
    logic [3:0]  class_d;
    logic [9:0]  in_addr_d;
    logic [14:0] wh_addr_d;
    logic [8:0]  wo_addr_d;
    logic [10:0] lut_addr_d;
`ifdef NN_SCORE_OUT_EN
    logic signed [7:0] max_score_d;
`endif

    nn_core_param u_dut_d (
        .clk       (clk),
        .rst_n     (rst_n_d),
        .start     (start_d),
        .busy      (busy_d),
        .done      (done_d),
        .class_idx (class_d),
        .in_addr   (in_addr_d),
        .in_q      (1'b0),
        .wh_addr   (wh_addr_d),
        .wh_q      (8'sd0),
        .wo_addr   (wo_addr_d),
        .wo_q      (8'sd0),
        .lut_addr  (lut_addr_d),
`ifdef NN_SCORE_OUT_EN
        .max_score (max_score_d),
`endif
        .lut_q     (8'sh10)
    );

    // ---------------- small instance ----------------
    logic        rst_n_s = 1'b0, start_s = 1'b0;
    logic        busy_s, done_s;
    logic [1:0]  class_s;
    logic [3:0]  in_addr_s;
    logic [5:0]  wh_addr_s;
    logic [3:0]  wo_addr_s;
    logic [10:0] lut_addr_s;
    logic        in_q_s;
    logic signed [7:0] wh_q_s, wo_q_s, lut_q_s;
`ifdef NN_SCORE_OUT_EN
    logic signed [7:0] max_score_s;
`endif

    nn_core_param #(.N_IN(16), .N_HID(4), .N_OUT(3)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n_s),
        .start     (start_s),
        .busy      (busy_s),
        .done      (done_s),
        .class_idx (class_s),
        .in_addr   (in_addr_s),
        .in_q      (in_q_s),
        .wh_addr   (wh_addr_s),
        .wh_q      (wh_q_s),
        .wo_addr   (wo_addr_s),
        .wo_q      (wo_q_s),
        .lut_addr  (lut_addr_s),
`ifdef NN_SCORE_OUT_EN
        .max_score (max_score_s),
`endif
        .lut_q     (lut_q_s)
    );

    logic              pix    [16];
    logic signed [7:0] wh_mem [64];
    logic signed [7:0] wo_mem [16];
    logic [10:0]       exp_hlut [4];
    logic [10:0]       exp_olut [3];

    // LUT contents: signed index (address minus bias) divided by 8.
    function automatic logic signed [7:0] lut_fn(input logic [10:0] a);
        int v;
        v = int'(a) - 1024;
        return 8'(v >>> 3);
    endfunction

    always @(posedge clk) begin
        in_q_s  <= pix[in_addr_s];
        wh_q_s  <= wh_mem[wh_addr_s];
        wo_q_s  <= wo_mem[wo_addr_s];
        lut_q_s <= lut_fn(lut_addr_s);
    end

    task automatic set_wo(input int o, input int w0, input int w1, input int w2, input int w3);
        wo_mem[o*4+0] = 8'(w0);
        wo_mem[o*4+1] = 8'(w1);
        wo_mem[o*4+2] = 8'(w2);
        wo_mem[o*4+3] = 8'(w3);
    endtask

    task automatic run_small(input string name, input int exp_cls, input int exp_max, input bit pulse);
        int done_k, done_n, prev_cls;
        prev_cls = int'(class_s);
        done_k   = -1;
        done_n   = 0;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        check_val({name, "_busy_start"}, busy_s, 1);
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (done_s) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            for (int j = 0; j < 4; j++)
                if (k == j*20 + 18) check_val($sformatf("%s_hlut%0d", name, j), lut_addr_s, exp_hlut[j]);
            for (int o = 0; o < 3; o++)
                if (k == 80 + o*8 + 6) check_val($sformatf("%s_olut%0d", name, o), lut_addr_s, exp_olut[o]);
            if (k == 5) begin
                check_val({name, "_in_addr5"}, in_addr_s, 5);
                check_val({name, "_wh_addr5"}, wh_addr_s, 5);
            end
            if (k == 43) begin
                check_val({name, "_in_addr43"}, in_addr_s, 3);
                check_val({name, "_wh_addr43"}, wh_addr_s, 35);
            end
            if (k == 90)  check_val({name, "_wo_addr90"}, wo_addr_s, 6);
            if (k == 104) begin
                check_val({name, "_class_held"}, class_s, prev_cls);
                check_val({name, "_busy_mid"}, busy_s, 1);
            end
            if (k == 105) check_val({name, "_busy_end"}, busy_s, 0);
            if (pulse && k == 99)  start_s = 1'b1;
            if (pulse && k == 100) start_s = 1'b0;
        end
        check_val({name, "_done_cycle"}, done_k, 105);
        check_val({name, "_done_count"}, done_n, 1);
        check_val({name, "_class"}, class_s, exp_cls);
`ifdef NN_SCORE_OUT_EN
        check_val({name, "_max_score"}, max_score_s, exp_max);
`endif
        $display("run %s done_at=%0d dones=%0d class=%0d expected_max=%0d", name, done_k, done_n, class_s, exp_max);
    endtask

    initial begin
        int done_k, done_n;
        for (int i = 0; i < 16; i++) begin
            pix[i]         = 1'b1;
            wh_mem[i]      = 8'sd127;
            wh_mem[16 + i] = -8'sd128;
            wh_mem[32 + i] = 8'sd0;
            wh_mem[48 + i] = 8'(i - 8);
            wo_mem[i]      = 8'sd0;
        end
        exp_hlut[0] = 11'h7FF;
        exp_hlut[1] = 11'h000;
        exp_hlut[2] = 11'h400;
        exp_hlut[3] = 11'h3F8;

        repeat (3) @(negedge clk);
        check_val("rst_busy", busy_d, 0);
        check_val("rst_done", done_d, 0);
        check_val("rst_class", class_d, 0);
        check_val("rst_wh_addr", wh_addr_d, 0);
        check_val("rst_lut_addr", lut_addr_d, 0);
        check_val("rst_s_wo_addr", wo_addr_s, 0);
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;

        // Small network: winner output 1, then a tie, then an all-negative field.
        set_wo(0, 64, 0, 0, 0);
        set_wo(1, 0, -64, 0, 0);
        set_wo(2, 0, 0, 5, -100);
        exp_olut[0] = 11'h43F; exp_olut[1] = 11'h440; exp_olut[2] = 11'h400;
        run_small("winner1", 1, 8, 1'b0);

        set_wo(0, 64, 0, 0, 0);
        set_wo(1, 64, 0, 0, 0);
        set_wo(2, -64, 0, 0, 0);
        exp_olut[0] = 11'h43F; exp_olut[1] = 11'h43F; exp_olut[2] = 11'h3C0;
        run_small("tie_pulse", 0, 7, 1'b1);

        set_wo(0, -64, 0, 0, 0);
        set_wo(1, 0, 64, 0, 0);
        set_wo(2, -32, 0, 0, 0);
        exp_olut[0] = 11'h3C0; exp_olut[1] = 11'h3C0; exp_olut[2] = 11'h3E0;
        run_small("negative", 2, -4, 1'b0);

        // Default size, all pixels zero, constant LUT: tie on every class.
        done_k = -1; done_n = 0;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        for (int k = 1; k <= 25600; k++) begin
            @(negedge clk);
            if (done_d) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == 786) check_val("dflt_hlut0", lut_addr_d, 11'h400);
        end
        check_val("dflt_done_cycle", done_k, 25577);
        check_val("dflt_done_count", done_n, 1);
        check_val("dflt_class", class_d, 0);
        $display("run dflt done_at=%0d dones=%0d class=%0d", done_k, done_n, class_d);

        // Abort at cycle 5000, then a clean run.
        done_n = 0;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (done_d) done_n++;
        end
        check_val("abort_busy_before", busy_d, 1);
        rst_n_d = 1'b0;
        #1;
        check_val("abort_busy", busy_d, 0);
        check_val("abort_wh_addr", wh_addr_d, 0);
        check_val("abort_in_addr", in_addr_d, 0);
        @(negedge clk); rst_n_d = 1'b1;
        done_k = -1;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        for (int k = 1; k <= 25600; k++) begin
            @(negedge clk);
            if (done_d) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
        end
        check_val("restart_done_cycle", done_k, 25577);
        check_val("restart_done_count", done_n, 1);
        $display("run restart done_at=%0d dones=%0d", done_k, done_n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
